x2050lad_arb: RTL and testbench

Cycle arbiter and sequencer for the L-register adder-input gate (x2050lad). It shares the gate between two requesters: the CPU microprogram and the multiplexor channel. Each cycle it picks at most one operation, registers that operation's gate controls (io_mode, lx, tc, e, ioreg), and returns the gate's xg/xin outputs one cycle later, tagged with the owning requester. It sits between ROS decode / channel logic and u_lad.

---
 rtl/x2050lad_arb.sv | 168 ++++++++++++++++
 tb/tb_x2050lad_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/x2050lad_arb.sv
// x2050lad_arb: shares the L-register adder-input gate between the CPU microprogram and the
// multiplexor channel; registers the winning op's gate controls and returns xg/xin two cycles later.
module x2050lad_arb #(
   parameter int unsigned CH_MAX   = 3,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_cpu_valid,
   output logic        o_cpu_ready,
   input  logic        i_cpu_io_mode,
   input  logic [2:0]  i_cpu_lx,
   input  logic        i_cpu_tc,
   input  logic [3:0]  i_cpu_e,
   input  logic        i_ch_valid,
   output logic        o_ch_ready,
   input  logic [2:0]  i_ch_lx,
   input  logic        i_ch_tc,
   input  logic [3:0]  i_ch_e,
   input  logic [1:0]  i_ch_ioreg,
   input  logic        i_ch_lock,
   output logic        o_lad_io_mode,
   output logic [2:0]  o_lad_lx,
   output logic        o_lad_tc,
   output logic [3:0]  o_lad_e,
   output logic [1:0]  o_lad_ioreg,
   input  logic [31:0] i_lad_xg,
   input  logic [31:0] i_lad_xin,
   output logic        o_res_valid,
   output logic        o_res_owner,
   output logic [31:0] o_res_xg,
   output logic [31:0] o_res_xin,
   output logic        o_lock_err
);

   localparam logic [3:0] STREAK_MAX = 4'(CH_MAX);
   localparam logic [7:0] LOCK_TMO   = 8'(LOCK_MAX);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

   typedef struct packed {
      logic       io_mode;
      logic [2:0] lx;
      logic       tc;
      logic [3:0] e;
      logic [1:0] ioreg;
   } lad_ctl_t;

   lock_state_e state_q, state_d;
   logic [3:0]  streak_q, streak_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic        lock_err_q, lock_err_d;
   lad_ctl_t    ctl_q, ctl_d;
   logic [1:0]  vld_pipe_q, vld_pipe_d;
   logic [1:0]  own_pipe_q, own_pipe_d;
   logic [31:0] res_xg_q, res_xg_d;
   logic [31:0] res_xin_q, res_xin_d;
   logic        cpu_xfer, ch_xfer;

   // Grant: lock first, then starvation override, then channel priority.
   always_comb begin
      cpu_xfer = 1'b0;
      ch_xfer  = 1'b0;
      if (!rst) begin
         if (state_q == LOCKED)
            ch_xfer = i_ch_valid;
         else if (streak_q == STREAK_MAX && i_cpu_valid)
            cpu_xfer = 1'b1;
         else if (i_ch_valid)
            ch_xfer = 1'b1;
         else
            cpu_xfer = i_cpu_valid;
      end
   end

   assign o_cpu_ready = cpu_xfer;
   assign o_ch_ready  = ch_xfer;

   always_comb begin
      state_d    = state_q;
      streak_d   = streak_q;
      lock_cnt_d = lock_cnt_q;
      lock_err_d = 1'b0;
      if (state_q == LOCKED) begin
         // A channel transfer beats a timeout landing in the same cycle.
         if (ch_xfer) begin
            lock_cnt_d = '0;
            state_d    = i_ch_lock ? LOCKED : UNLOCKED;
         end else if (lock_cnt_q == LOCK_TMO) begin
            lock_cnt_d = '0;
            state_d    = UNLOCKED;
            lock_err_d = 1'b1;
         end else begin
            lock_cnt_d = lock_cnt_q + 8'd1;
         end
      end else begin
         if (ch_xfer && i_ch_lock) begin
            state_d    = LOCKED;
            lock_cnt_d = '0;
         end
         if (!i_cpu_valid || cpu_xfer)
            streak_d = '0;
         else if (ch_xfer)
            streak_d = streak_q + 4'd1;
      end
   end

   // ioreg is only ever written by the channel; CPU io-mode ops read the channel's value.
   always_comb begin
      ctl_d         = '0;
      ctl_d.ioreg   = ctl_q.ioreg;
      if (cpu_xfer) begin
         ctl_d.io_mode = i_cpu_io_mode;
         ctl_d.lx      = i_cpu_lx;
         ctl_d.tc      = i_cpu_tc;
         ctl_d.e       = i_cpu_e;
      end else if (ch_xfer) begin
         ctl_d.io_mode = 1'b1;
         ctl_d.lx      = i_ch_lx;
         ctl_d.tc      = i_ch_tc;
         ctl_d.e       = i_ch_e;
         ctl_d.ioreg   = i_ch_ioreg;
      end
   end

   always_comb begin
      vld_pipe_d = {vld_pipe_q[0], cpu_xfer | ch_xfer};
      own_pipe_d = {own_pipe_q[0], ch_xfer};
      res_xg_d   = vld_pipe_q[0] ? i_lad_xg  : res_xg_q;
      res_xin_d  = vld_pipe_q[0] ? i_lad_xin : res_xin_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= UNLOCKED;
         streak_q   <= '0;
         lock_cnt_q <= '0;
         lock_err_q <= 1'b0;
         ctl_q      <= '0;
         vld_pipe_q <= '0;
         own_pipe_q <= '0;
         res_xg_q   <= '0;
         res_xin_q  <= '0;
      end else begin
         state_q    <= state_d;
         streak_q   <= streak_d;
         lock_cnt_q <= lock_cnt_d;
         lock_err_q <= lock_err_d;
         ctl_q      <= ctl_d;
         vld_pipe_q <= vld_pipe_d;
         own_pipe_q <= own_pipe_d;
         res_xg_q   <= res_xg_d;
         res_xin_q  <= res_xin_d;
      end
   end

   assign o_lad_io_mode = ctl_q.io_mode;
   assign o_lad_lx      = ctl_q.lx;
   assign o_lad_tc      = ctl_q.tc;
   assign o_lad_e       = ctl_q.e;
   assign o_lad_ioreg   = ctl_q.ioreg;
   assign o_res_valid   = vld_pipe_q[1];
   assign o_res_owner   = own_pipe_q[1];
   assign o_res_xg      = res_xg_q;
   assign o_res_xin     = res_xin_q;
   assign o_lock_err    = lock_err_q;

endmodule

// File: tb/tb_x2050lad_arb.sv
// Directed bench for x2050lad_arb; a stand-in gate drives xg/xin from the registered controls.
module tb_x2050lad_arb;

   logic        clk, rst;
   logic        i_cpu_valid, o_cpu_ready, i_cpu_io_mode, i_cpu_tc;
   logic [2:0]  i_cpu_lx;
   logic [3:0]  i_cpu_e;
   logic        i_ch_valid, o_ch_ready, i_ch_tc, i_ch_lock;
   logic [2:0]  i_ch_lx;
   logic [3:0]  i_ch_e;
   logic [1:0]  i_ch_ioreg;
   logic        o_lad_io_mode, o_lad_tc;
   logic [2:0]  o_lad_lx;
   logic [3:0]  o_lad_e;
   logic [1:0]  o_lad_ioreg;
   logic [31:0] i_lad_xg, i_lad_xin;
   logic        o_res_valid, o_res_owner, o_lock_err;
   logic [31:0] o_res_xg, o_res_xin;
   logic [31:0] l_reg;
   int          checks = 0;
   int          errors = 0;

   x2050lad_arb #(.CH_MAX(3), .LOCK_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .i_cpu_valid(i_cpu_valid), .o_cpu_ready(o_cpu_ready),
      .i_cpu_io_mode(i_cpu_io_mode), .i_cpu_lx(i_cpu_lx), .i_cpu_tc(i_cpu_tc), .i_cpu_e(i_cpu_e),
      .i_ch_valid(i_ch_valid), .o_ch_ready(o_ch_ready),
      .i_ch_lx(i_ch_lx), .i_ch_tc(i_ch_tc), .i_ch_e(i_ch_e), .i_ch_ioreg(i_ch_ioreg),
      .i_ch_lock(i_ch_lock),
      .o_lad_io_mode(o_lad_io_mode), .o_lad_lx(o_lad_lx), .o_lad_tc(o_lad_tc),
      .o_lad_e(o_lad_e), .o_lad_ioreg(o_lad_ioreg),
      .i_lad_xg(i_lad_xg), .i_lad_xin(i_lad_xin),
      .o_res_valid(o_res_valid), .o_res_owner(o_res_owner),
      .o_res_xg(o_res_xg), .o_res_xin(o_res_xin), .o_lock_err(o_lock_err)
   );

   // Stand-in gate: xg = L when lx selects it, else the packed controls; xin = L or ~L by tc.
   assign i_lad_xg  = (o_lad_lx != 3'd0) ? l_reg
                      : {24'd0, o_lad_io_mode, o_lad_ioreg, o_lad_e, o_lad_tc};
   assign i_lad_xin = o_lad_tc ? l_reg : ~l_reg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      i_cpu_valid = 0; i_cpu_io_mode = 0; i_cpu_lx = 0; i_cpu_tc = 0; i_cpu_e = 0;
      i_ch_valid = 0; i_ch_lx = 0; i_ch_tc = 0; i_ch_e = 0; i_ch_ioreg = 0; i_ch_lock = 0;
   endtask

   task automatic test_reset();
      idle();
      l_reg = 32'h0;
      rst = 1'b1;
      i_cpu_valid = 1; i_ch_valid = 1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if ({o_cpu_ready, o_ch_ready} !== 2'b00) begin errors++;
         $display("FAIL rst_ready got %b exp 00", {o_cpu_ready, o_ch_ready}); end
      checks++; if ({o_lad_io_mode, o_lad_lx, o_lad_tc, o_lad_e, o_lad_ioreg} !== 11'd0) begin errors++;
         $display("FAIL rst_lad got %h exp 0", {o_lad_io_mode, o_lad_lx, o_lad_tc, o_lad_e, o_lad_ioreg}); end
      checks++; if ({o_res_valid, o_res_owner, o_lock_err} !== 3'b000) begin errors++;
         $display("FAIL rst_flags got %b exp 000", {o_res_valid, o_res_owner, o_lock_err}); end
      checks++; if ({o_res_xg, o_res_xin} !== 64'd0) begin errors++;
         $display("FAIL rst_res got %h exp 0", {o_res_xg, o_res_xin}); end
      idle();
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      l_reg = 32'h1234_5678;
      i_cpu_valid = 1; i_cpu_lx = 3'd1; i_cpu_tc = 1;
      #1;
      checks++; if (o_cpu_ready !== 1'b1) begin errors++;
         $display("FAIL basic_ready got %b exp 1", o_cpu_ready); end
      @(negedge clk); idle(); #1;
      checks++; if ({o_lad_lx, o_lad_tc, o_res_valid} !== 5'b001_1_0) begin errors++;
         $display("FAIL basic_lad got %b exp 00110", {o_lad_lx, o_lad_tc, o_res_valid}); end
      @(negedge clk); #1;
      checks++; if ({o_res_valid, o_res_owner} !== 2'b10) begin errors++;
         $display("FAIL basic_res_flags got %b exp 10", {o_res_valid, o_res_owner}); end
      checks++; if ({o_res_xg, o_res_xin} !== 64'h12345678_12345678) begin errors++;
         $display("FAIL basic_res_data got %h exp 1234567812345678", {o_res_xg, o_res_xin}); end
      @(negedge clk); #1;
      checks++; if ({o_res_valid, o_res_xg} !== {1'b0, 32'h1234_5678}) begin errors++;
         $display("FAIL basic_hold got %h exp 012345678", {o_res_valid, o_res_xg}); end
   endtask

   task automatic test_channel();
      l_reg = 32'hA5A5_0F0F;
      i_ch_valid = 1; i_ch_lx = 0; i_ch_tc = 0; i_ch_e = 4'h3; i_ch_ioreg = 2'd2;
      #1;
      checks++; if ({o_ch_ready, o_cpu_ready} !== 2'b10) begin errors++;
         $display("FAIL ch_ready got %b exp 10", {o_ch_ready, o_cpu_ready}); end
      @(negedge clk); idle();
      i_cpu_valid = 1; i_cpu_io_mode = 1; i_cpu_lx = 3'd6;
      #1;
      checks++; if ({o_lad_io_mode, o_lad_ioreg, o_lad_lx} !== 6'b1_10_000) begin errors++;
         $display("FAIL ch_lad got %b exp 110000", {o_lad_io_mode, o_lad_ioreg, o_lad_lx}); end
      checks++; if (o_cpu_ready !== 1'b1) begin errors++;
         $display("FAIL ch_cpu_ready got %b exp 1", o_cpu_ready); end
      @(negedge clk); idle(); #1;
      checks++; if ({o_res_valid, o_res_owner} !== 2'b11) begin errors++;
         $display("FAIL ch_res_flags got %b exp 11", {o_res_valid, o_res_owner}); end
      checks++; if ({o_res_xg, o_res_xin} !== 64'h000000C6_5A5AF0F0) begin errors++;
         $display("FAIL ch_res_data got %h exp 000000c65a5af0f0", {o_res_xg, o_res_xin}); end
      checks++; if ({o_lad_io_mode, o_lad_lx, o_lad_ioreg} !== 6'b1_110_10) begin errors++;
         $display("FAIL cpu_ioreg_keep got %b exp 111010", {o_lad_io_mode, o_lad_lx, o_lad_ioreg}); end
      @(negedge clk); #1;
      checks++; if ({o_res_valid, o_res_owner, o_res_xg} !== {2'b10, 32'hA5A5_0F0F}) begin errors++;
         $display("FAIL ch_cpu_res got %h exp 2a5a50f0f", {o_res_valid, o_res_owner, o_res_xg}); end
      checks++; if ({o_lad_lx, o_lad_ioreg} !== 5'b000_10) begin errors++;
         $display("FAIL idle_ioreg got %b exp 00010", {o_lad_lx, o_lad_ioreg}); end
   endtask

   task automatic test_starvation();
      logic [7:0] exp_ch;
      logic       e_own;
      exp_ch = 8'b0111_0111;  // bit i = grant in cycle i, 1 = channel
      l_reg  = 32'h0F1E_2D3C;
      for (int i = 0; i < 11; i++) begin
         idle();
         if (i < 8) begin
            i_cpu_valid = 1; i_cpu_lx = 3'd1; i_cpu_tc = 1;
            i_ch_valid = 1; i_ch_e = 4'h5; i_ch_ioreg = 2'd1;
         end
         #1;
         if (i < 8) begin
            checks++; if ({o_ch_ready, o_cpu_ready} !== {exp_ch[i], ~exp_ch[i]}) begin errors++;
               $display("FAIL starve_grant%0d got %b exp %b", i, {o_ch_ready, o_cpu_ready},
                        {exp_ch[i], ~exp_ch[i]}); end
         end
         if (i >= 2 && i < 10) begin
            e_own = exp_ch[i-2];
            checks++; if ({o_res_valid, o_res_owner} !== {1'b1, e_own}) begin errors++;
               $display("FAIL starve_res%0d got %b exp %b", i - 2, {o_res_valid, o_res_owner},
                        {1'b1, e_own}); end
            checks++; if (o_res_xg !== (e_own ? 32'h0000_00AA : 32'h0F1E_2D3C)) begin errors++;
               $display("FAIL starve_xg%0d got %h exp %h", i - 2, o_res_xg,
                        e_own ? 32'h0000_00AA : 32'h0F1E_2D3C); end
         end
         if (i == 10) begin
            checks++; if (o_res_valid !== 1'b0) begin errors++;
               $display("FAIL starve_end got %b exp 0", o_res_valid); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lock();
      // 0: lock, 1-4 idle, 5 renew, 6-8 idle, 9 unlock, 10 CPU alone
      for (int i = 0; i < 11; i++) begin
         idle();
         i_cpu_valid = 1;
         i_ch_valid  = (i == 0 || i == 5 || i == 9);
         i_ch_lock   = (i != 9);
         #1;
         checks++; if ({o_ch_ready, o_cpu_ready, o_lock_err} !== {i_ch_valid, i == 10, 1'b0}) begin
            errors++;
            $display("FAIL lock_cyc%0d got %b exp %b", i, {o_ch_ready, o_cpu_ready, o_lock_err},
                     {i_ch_valid, i == 10, 1'b0}); end
         @(negedge clk);
      end
      idle();
      @(negedge clk);
   endtask

   task automatic test_lock_timeout();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 13; i++) begin
         idle();
         i_cpu_valid = (i <= 10);
         i_ch_valid  = (i == 0);
         i_ch_lock   = 1;
         #1;
         pulses += int'(o_lock_err);
         if (i >= 1 && i <= 10) begin
            checks++; if ({o_cpu_ready, o_lock_err} !== {i == 10, i == 10}) begin errors++;
               $display("FAIL tmo_cyc%0d got %b exp %b", i, {o_cpu_ready, o_lock_err},
                        {i == 10, i == 10}); end
         end
         @(negedge clk);
      end
      checks++; if (pulses !== 1) begin errors++;
         $display("FAIL tmo_pulses got %0d exp 1", pulses); end
   endtask

   task automatic test_lock_race();
      // Unlocking transfer lands on the timeout cycle: no error, lock released.
      for (int i = 0; i < 12; i++) begin
         idle();
         i_cpu_valid = (i >= 10);
         i_ch_valid  = (i == 0 || i == 9);
         i_ch_lock   = (i == 0);
         #1;
         if (i == 9) begin
            checks++; if (o_ch_ready !== 1'b1) begin errors++;
               $display("FAIL race_ch got %b exp 1", o_ch_ready); end
         end
         if (i >= 10) begin
            checks++; if ({o_cpu_ready, o_lock_err} !== 2'b10) begin errors++;
               $display("FAIL race_cyc%0d got %b exp 10", i, {o_cpu_ready, o_lock_err}); end
         end
         @(negedge clk);
      end
      idle();
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      l_reg = 32'hCAFE_F00D;
      i_ch_valid = 1; i_ch_lock = 1; i_ch_lx = 3'd2; i_ch_tc = 1; i_ch_e = 4'h9; i_ch_ioreg = 2'd3;
      #1;
      checks++; if (o_ch_ready !== 1'b1) begin errors++;
         $display("FAIL mid_ch got %b exp 1", o_ch_ready); end
      @(negedge clk); idle(); rst = 1'b1;
      @(negedge clk); #1;
      checks++; if ({o_res_valid, o_res_owner, o_lock_err, o_cpu_ready, o_ch_ready} !== 5'd0) begin
         errors++;
         $display("FAIL mid_flags got %b exp 00000",
                  {o_res_valid, o_res_owner, o_lock_err, o_cpu_ready, o_ch_ready}); end
      checks++; if ({o_lad_io_mode, o_lad_lx, o_lad_tc, o_lad_e, o_lad_ioreg, o_res_xg, o_res_xin}
                    !== 75'd0) begin errors++;
         $display("FAIL mid_data got %h exp 0",
                  {o_lad_io_mode, o_lad_lx, o_lad_tc, o_lad_e, o_lad_ioreg, o_res_xg, o_res_xin}); end
      rst = 1'b0;
      i_cpu_valid = 1; i_cpu_lx = 3'd1; i_cpu_tc = 1;
      #1;
      checks++; if (o_cpu_ready !== 1'b1) begin errors++;
         $display("FAIL mid_unlocked got %b exp 1", o_cpu_ready); end
      @(negedge clk); idle(); #1;
      checks++; if (o_res_valid !== 1'b0) begin errors++;
         $display("FAIL mid_no_res got %b exp 0", o_res_valid); end
      @(negedge clk); #1;
      checks++; if ({o_res_valid, o_res_owner, o_res_xg} !== {2'b10, 32'hCAFE_F00D}) begin errors++;
         $display("FAIL mid_recover got %h exp 2cafef00d", {o_res_valid, o_res_owner, o_res_xg}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_channel();
      test_starvation();
      test_lock();
      test_lock_timeout();
      test_lock_race();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
